// File: rtl/jedro_1_defines.sv
// ---------------------------------------------------------------------------
// jedro_1_defines
// Shared types and constants for the jedro_1 memory subsystem.
//   mem_owner_e   : which requester owns the RAM response arriving next cycle
//   MEM_BE_WIDTH  : number of byte lanes on the data port
//   GNT_IFU/LSU   : bit positions inside the arbiter grant vector
//   sat_inc4      : saturating 4-bit increment used by the starvation counter
// ---------------------------------------------------------------------------
package jedro_1_defines;

  localparam int MEM_BE_WIDTH = 4;

  localparam int GNT_IFU = 0;
  localparam int GNT_LSU = 1;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IFU_RD,
    OWN_LSU_RD,
    OWN_LSU_WR
  } mem_owner_e;

  // Counts up by one but never past lim.
  function automatic logic [3:0] sat_inc4(input logic [3:0] value, input logic [3:0] lim);
    return (value >= lim) ? lim : value + 4'd1;
  endfunction

endpackage

// File: rtl/jedro_1_mem_arb_prio.sv
// ---------------------------------------------------------------------------
// jedro_1_mem_arb_prio
// Combinational priority selection between instruction fetch and load/store,
// plus the starvation counter that eventually forces an instruction grant.
// Ports:
//   clk_i, rstn_i : clock, asynchronous active-low reset
//   ifu_req_i     : instruction fetch request
//   lsu_req_i     : load/store request
//   gnt_o[1:0]    : one-hot (or zero) grant vector, bit GNT_IFU / GNT_LSU
// No grant is ever given while rstn_i is low, so nothing reaches the RAM
// during reset.
// ---------------------------------------------------------------------------
module jedro_1_mem_arb_prio
  import jedro_1_defines::*;
#(
  parameter int MAX_STARVE = 4
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       ifu_req_i,
  input  logic       lsu_req_i,
  output logic [1:0] gnt_o
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_STARVE);

  logic [3:0] starve_cnt_r;
  logic [3:0] starve_cnt_d;

  // Data accesses win a conflict, except when the instruction port has been
  // refused MAX_STARVE cycles in a row; a lone requester always wins.
  always_comb begin
    gnt_o = 2'b00;
    if (rstn_i) begin
      if (ifu_req_i && lsu_req_i) begin
        if (starve_cnt_r == MAX_CNT) begin
          gnt_o[GNT_IFU] = 1'b1;
        end else begin
          gnt_o[GNT_LSU] = 1'b1;
        end
      end else if (ifu_req_i) begin
        gnt_o[GNT_IFU] = 1'b1;
      end else if (lsu_req_i) begin
        gnt_o[GNT_LSU] = 1'b1;
      end
    end
  end

  // The counter tracks an unbroken run of refused fetch cycles; any fetch
  // grant or a dropped fetch request restarts the run.
  always_comb begin
    starve_cnt_d = 4'd0;
    if (ifu_req_i && !gnt_o[GNT_IFU]) begin
      starve_cnt_d = sat_inc4(starve_cnt_r, MAX_CNT);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      starve_cnt_r <= 4'd0;
    end else begin
      starve_cnt_r <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/jedro_1_mem_arbiter.sv
// ---------------------------------------------------------------------------
// jedro_1_mem_arbiter
// Shares one single-port synchronous RAM (1-cycle read latency) between the
// instruction fetch unit (IFU) and the load/store unit (LSU).
// Ports:
//   clk_i, rstn_i          : clock, asynchronous active-low reset
//   ifu_req_i/addr_i       : fetch request and address
//   ifu_gnt_o              : fetch accepted this cycle
//   ifu_rvalid_o/rdata_o   : fetched word, one cycle after the grant
//   lsu_req_i/we_i/be_i    : data request, write flag, byte enables
//   lsu_addr_i/wdata_i     : data address and write data
//   lsu_gnt_o              : data access accepted this cycle
//   lsu_rvalid_o/rdata_o   : read word or write ack (rdata 0), next cycle
//   ram_en_o/we_o/addr_o/wdata_o : shared RAM request, driven combinationally
//   ram_rdata_i            : RAM read data, valid the cycle after ram_en_o
// Optional build macro JEDRO_1_MEM_ARB_STATS_EN adds wrapping counters
//   stat_conflict_o : cycles where both units requested
//   stat_starve_o   : conflicts resolved in favour of the starved IFU
// ---------------------------------------------------------------------------
module jedro_1_mem_arbiter
  import jedro_1_defines::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_STARVE = 4
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    ifu_req_i,
  input  logic [DATA_WIDTH-1:0]   ifu_addr_i,
  output logic                    ifu_gnt_o,
  output logic                    ifu_rvalid_o,
  output logic [DATA_WIDTH-1:0]   ifu_rdata_o,
  input  logic                    lsu_req_i,
  input  logic                    lsu_we_i,
  input  logic [MEM_BE_WIDTH-1:0] lsu_be_i,
  input  logic [DATA_WIDTH-1:0]   lsu_addr_i,
  input  logic [DATA_WIDTH-1:0]   lsu_wdata_i,
  output logic                    lsu_gnt_o,
  output logic                    lsu_rvalid_o,
  output logic [DATA_WIDTH-1:0]   lsu_rdata_o,
  output logic                    ram_en_o,
  output logic [MEM_BE_WIDTH-1:0] ram_we_o,
  output logic [DATA_WIDTH-1:0]   ram_addr_o,
  output logic [DATA_WIDTH-1:0]   ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]   ram_rdata_i
`ifdef JEDRO_1_MEM_ARB_STATS_EN
  ,
  output logic [31:0]             stat_conflict_o,
  output logic [31:0]             stat_starve_o
`endif
);

  logic [1:0] gnt;
  mem_owner_e owner_r;
  mem_owner_e owner_d;

  jedro_1_mem_arb_prio #(
    .MAX_STARVE (MAX_STARVE)
  ) u_prio (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .ifu_req_i (ifu_req_i),
    .lsu_req_i (lsu_req_i),
    .gnt_o     (gnt)
  );

  assign ifu_gnt_o = gnt[GNT_IFU];
  assign lsu_gnt_o = gnt[GNT_LSU];

  // Steer the winner onto the RAM port. With no winner the port is idle and
  // all its fields are held at zero. The IFU never writes, so it drives zero
  // write data.
  always_comb begin
    ram_en_o    = 1'b0;
    ram_we_o    = '0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    if (gnt[GNT_IFU]) begin
      ram_en_o   = 1'b1;
      ram_addr_o = ifu_addr_i;
    end else if (gnt[GNT_LSU]) begin
      ram_en_o    = 1'b1;
      ram_addr_o  = lsu_addr_i;
      ram_wdata_o = lsu_wdata_i;
      if (lsu_we_i) begin
        ram_we_o = lsu_be_i;
      end
    end
  end

  // Remember who was granted this cycle so the RAM response arriving next
  // cycle can be routed back to the right unit. Reset drops any pending
  // response immediately.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      owner_r <= OWN_NONE;
    end else begin
      owner_r <= owner_d;
    end
  end

  // Next owner comes straight from this cycle's grant; response outputs are
  // decoded from the current owner and pass the RAM data through unregistered.
  always_comb begin
    owner_d      = OWN_NONE;
    ifu_rvalid_o = 1'b0;
    ifu_rdata_o  = '0;
    lsu_rvalid_o = 1'b0;
    lsu_rdata_o  = '0;

    if (gnt[GNT_IFU]) begin
      owner_d = OWN_IFU_RD;
    end else if (gnt[GNT_LSU]) begin
      owner_d = lsu_we_i ? OWN_LSU_WR : OWN_LSU_RD;
    end

    unique case (owner_r)
      OWN_IFU_RD: begin
        ifu_rvalid_o = 1'b1;
        ifu_rdata_o  = ram_rdata_i;
      end
      OWN_LSU_RD: begin
        lsu_rvalid_o = 1'b1;
        lsu_rdata_o  = ram_rdata_i;
      end
      OWN_LSU_WR: begin
        lsu_rvalid_o = 1'b1;
      end
      default: begin
      end
    endcase
  end

`ifdef JEDRO_1_MEM_ARB_STATS_EN
  logic conflict;
  logic forced;

  assign conflict = ifu_req_i && lsu_req_i;
  assign forced   = conflict && gnt[GNT_IFU];

  // Free-running wrap-around event counters.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      stat_conflict_o <= 32'd0;
      stat_starve_o   <= 32'd0;
    end else begin
      if (conflict) begin
        stat_conflict_o <= stat_conflict_o + 32'd1;
      end
      if (forced) begin
        stat_starve_o <= stat_starve_o + 32'd1;
      end
    end
  end
`endif

endmodule
